// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared types and helpers for the uart_frame_rx deframer:
//               the state enum, the default start-of-frame byte and the
//               width helper for the inter-byte timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hAA;

    // Bits needed for a counter that must be able to hold the value CYCLES.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_rx_if
// Description : Byte input stream, payload output stream and status/error
//               strobes of the uart_frame_rx deframer.
//               slave  = deframer side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_rx_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] frm_data;
    logic       frm_valid;
    logic       frm_ready;
    logic       frm_last;
    logic [7:0] frm_len;
    logic       busy;
    logic       csum_err;
    logic       len_err;
    logic       timeout_err;
    logic       overrun_err;

    modport slave (
        input  in_data, in_valid, frm_ready,
        output frm_data, frm_valid, frm_last, frm_len, busy,
               csum_err, len_err, timeout_err, overrun_err
    );

    modport master (
        output in_data, in_valid, frm_ready,
        input  frm_data, frm_valid, frm_last, frm_len, busy,
               csum_err, len_err, timeout_err, overrun_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_buf
// Description : DEPTH x 8 payload buffer, one write port and one registered
//               read port. Storage has no reset. A write to the address being
//               read is forwarded so the read register never shows stale data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_buf #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);

    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage write; out-of-range addresses are ignored.
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i < DEPTH8)) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // Registered read with write-through forwarding.
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else if (raddr_i < DEPTH8) begin
            rdata_q <= mem_q[raddr_i[AW-1:0]];
        end else begin
            rdata_q <= 8'h00;
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_rx
// Description : Deframer for SOF, LEN, payload [, checksum] byte frames coming
//               from uart_rx. Complete frames are drained on a valid/ready
//               stream; malformed frames are dropped with an error strobe.
//               Build option: UART_FRAME_CSUM_EN enables the trailing
//               checksum byte and csum_err (otherwise csum_err is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 125000
) (
    input  logic            clk,
    input  logic            rst,
    uart_frame_rx_if.slave  bus
);

    localparam int         TW   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [7:0] MAX8 = 8'(MAX_LEN);
`ifdef UART_FRAME_CSUM_EN
    localparam state_t ST_AFTER_PAYLOAD = ST_CSUM;
`else
    localparam state_t ST_AFTER_PAYLOAD = ST_DRAIN;
`endif

    state_t          state_q, state_d;
    logic            in_valid_q;
    logic [7:0]      len_q, len_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      rd_idx_q, rd_idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            len_err_q, len_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            overrun_err_q, overrun_err_d;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0]      sum_q, sum_d;
    logic            csum_err_q, csum_err_d;
`endif

    logic            w_accept;
    logic            w_tmo_hit;
    logic            w_xfer;
    logic            w_last;
    logic            buf_we;
    logic [7:0]      buf_rdata;

    assign w_accept  = bus.in_valid & ~in_valid_q;
    assign w_tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));
    assign w_xfer    = (state_q == ST_DRAIN) & bus.frm_ready;
    assign w_last    = (rd_idx_q == (len_q - 8'd1));

    // State, counters and error strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            in_valid_q    <= 1'b0;
            len_q         <= 8'd0;
            idx_q         <= 8'd0;
            rd_idx_q      <= 8'd0;
            tmo_q         <= '0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
            sum_q         <= 8'd0;
            csum_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            in_valid_q    <= bus.in_valid;
            len_q         <= len_d;
            idx_q         <= idx_d;
            rd_idx_q      <= rd_idx_d;
            tmo_q         <= tmo_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_FRAME_CSUM_EN
            sum_q         <= sum_d;
            csum_err_q    <= csum_err_d;
`endif
        end
    end

    // Next-state: frame parsing, timeout supervision and drain sequencing.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        rd_idx_d      = rd_idx_q;
        tmo_d         = '0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        overrun_err_d = 1'b0;
        buf_we        = 1'b0;
`ifdef UART_FRAME_CSUM_EN
        sum_d         = sum_q;
        csum_err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                idx_d    = 8'd0;
                rd_idx_d = 8'd0;
                if (w_accept && (bus.in_data == SOF)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    if ((bus.in_data == 8'd0) || (bus.in_data > MAX8)) begin
                        len_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        len_d   = bus.in_data;
                        idx_d   = 8'd0;
`ifdef UART_FRAME_CSUM_EN
                        sum_d   = bus.in_data;
`endif
                        state_d = ST_PAYLOAD;
                    end
                end else if (w_tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + 8'd1;
`ifdef UART_FRAME_CSUM_EN
                    sum_d  = sum_q + bus.in_data;
`endif
                    if ((idx_q + 8'd1) == len_q) begin
                        state_d = ST_AFTER_PAYLOAD;
                    end
                end else if (w_tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
`ifdef UART_FRAME_CSUM_EN
            ST_CSUM: begin
                if (w_accept) begin
                    if ((sum_q + bus.in_data) == 8'h00) begin
                        state_d = ST_DRAIN;
                    end else begin
                        csum_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
`endif
            ST_DRAIN: begin
                overrun_err_d = w_accept;
                if (w_xfer) begin
                    if (w_last) begin
                        rd_idx_d = 8'd0;
                        state_d  = ST_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The read port fetches the entry that will be on frm_data next cycle.
    uart_frame_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (bus.in_data),
        .raddr_i (rd_idx_d),
        .rdata_o (buf_rdata)
    );

    assign bus.frm_valid   = (state_q == ST_DRAIN);
    assign bus.frm_data    = bus.frm_valid ? buf_rdata : 8'h00;
    assign bus.frm_last    = bus.frm_valid & w_last;
    assign bus.frm_len     = bus.frm_valid ? len_q : 8'h00;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.len_err     = len_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun_err = overrun_err_q;
`ifdef UART_FRAME_CSUM_EN
    assign bus.csum_err    = csum_err_q;
`else
    assign bus.csum_err    = 1'b0;
`endif

endmodule
`default_nettype wire
